rotation_scheduler: RTL and testbench

- Time-multiplexes one shared sin/cos lookup ROM pair (TrigLUT, 448 entries, 1-cycle registered read) across NUM_REQ sprite requesters that each need a point on a circle.
- Accepts (center, radius, angle index) per requester and arbitrates round-robin.
- Issues ROM addresses, applies quadrant signs, and returns one screen coordinate tagged with the requester id.
- Sits between the sprite/motion logic and the TrigLUT instances, replacing a per-sprite pair of ROMs.

---
 rtl/rot_pkg.sv | 24 ++
 rtl/rr_arbiter.sv | 37 +++
 rtl/rotation_scheduler.sv | 212 +++++++++++++++++++++
 tb/tb_rotation_scheduler.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rot_pkg.sv
// Shared types and constants for the rotation scheduler.
package rot_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WAIT,
    CALC,
    DONE
  } state_t;

  localparam int ANGLE_MIN  = 32;
  localparam int ANGLE_SPAN = 448;
  localparam int QUARTER    = 112;
  localparam int SCALE      = 1000;

  typedef logic [9:0] coord_t;

  // Fold an offset angle into the ROM address range [0, ANGLE_SPAN).
  function automatic logic [8:0] span_mod(input logic [10:0] v);
    return 9'(v % 11'(ANGLE_SPAN));
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin selector: first set request at or after rr_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int SEL_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   rr_ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [2:0]         id
);

  localparam int IW = SEL_W + 1;

  logic [IW-1:0] idx;
  logic          found;

  // Scan requesters starting at the pointer; the first hit wins.
  always_comb begin
    grant = '0;
    id    = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + IW'(k);
      if (idx >= IW'(NUM_REQ)) begin
        idx = idx - IW'(NUM_REQ);
      end
      if (enable && !found && req[idx[SEL_W-1:0]]) begin
        grant[idx[SEL_W-1:0]] = 1'b1;
        id                    = 3'(idx);
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rotation_scheduler.sv
// Shares one sin/cos ROM pair across NUM_REQ requesters, producing one
// circle point per transaction tagged with the requester id.
module rotation_scheduler
  import rot_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [NUM_REQ-1:0][9:0] center_x,
  input  logic [NUM_REQ-1:0][9:0] center_y,
  input  logic [NUM_REQ-1:0][9:0] radius,
  input  logic [NUM_REQ-1:0][9:0] angle,
  output logic [NUM_REQ-1:0]      grant,
  output logic [8:0]              cos_addr,
  output logic [8:0]              sin_addr,
  input  logic [9:0]              cos_data,
  input  logic [9:0]              sin_data,
  output logic                    out_valid,
  output logic [2:0]              out_id,
  output logic [9:0]              out_x,
  output logic [9:0]              out_y,
  output logic                    busy
);

  localparam int SEL_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [2:0]         out_id_q, out_id_d;
  coord_t             out_x_q, out_x_d;
  coord_t             out_y_q, out_y_d;
  logic [8:0]         cos_addr_q, cos_addr_d;
  logic [8:0]         sin_addr_q, sin_addr_d;

  coord_t             cx_q, cx_d;
  coord_t             cy_q, cy_d;
  coord_t             rad_q, rad_d;
  coord_t             ang_q, ang_d;
  logic [2:0]         id_q, id_d;
  logic [1:0]         quad_q, quad_d;
  logic               oor_q, oor_d;
  logic [9:0]         cos_q, cos_d;
  logic [9:0]         sin_q, sin_d;

  coord_t             rel;
  logic [19:0]        prod_x, prod_y;
  coord_t             px, py;

  logic [NUM_REQ-1:0] arb_grant;
  logic [2:0]         arb_id;

  // Which quarter of the circle an offset angle falls into.
  function automatic logic [1:0] quadrant_of(input coord_t r);
    if (r < 10'(QUARTER)) begin
      return 2'd0;
    end else if (r < 10'(2 * QUARTER)) begin
      return 2'd1;
    end else if (r < 10'(3 * QUARTER)) begin
      return 2'd2;
    end
    return 2'd3;
  endfunction

  // Signed offset applied with plain modulo-1024 wrap, no saturation.
  function automatic coord_t wrap_offset(input coord_t base, input coord_t off,
                                         input logic neg);
    return neg ? coord_t'(base - off) : coord_t'(base + off);
  endfunction

  rr_arbiter #(
    .NUM_REQ(NUM_REQ),
    .SEL_W  (SEL_W)
  ) u_arb (
    .req   (req),
    .rr_ptr(rr_ptr_q),
    .enable(state_q == IDLE),
    .grant (arb_grant),
    .id    (arb_id)
  );

  // Magnitudes from ROM are unsigned; quadrant decides the sign later.
  assign prod_x = 20'(rad_q) * 20'(cos_q);
  assign prod_y = 20'(rad_q) * 20'(sin_q);
  assign px     = 10'(prod_x / 20'(SCALE));
  assign py     = 10'(prod_y / 20'(SCALE));

  // Next-state and datapath decode for the five-step transaction.
  always_comb begin
    state_d     = state_q;
    grant_d     = '0;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = 1'b0;
    out_id_d    = out_id_q;
    out_x_d     = out_x_q;
    out_y_d     = out_y_q;
    cos_addr_d  = cos_addr_q;
    sin_addr_d  = sin_addr_q;
    cx_d        = cx_q;
    cy_d        = cy_q;
    rad_d       = rad_q;
    ang_d       = ang_q;
    id_d        = id_q;
    quad_d      = quad_q;
    oor_d       = oor_q;
    cos_d       = cos_q;
    sin_d       = sin_q;
    rel         = ang_q - 10'(ANGLE_MIN);

    case (state_q)
      IDLE: begin
        if (|req) begin
          grant_d = arb_grant;
          id_d    = arb_id;
          for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_grant[i]) begin
              cx_d  = center_x[i];
              cy_d  = center_y[i];
              rad_d = radius[i];
              ang_d = angle[i];
            end
          end
          state_d = ADDR;
        end
      end
      ADDR: begin
        cos_addr_d = span_mod({1'b0, rel});
        sin_addr_d = span_mod({1'b0, rel} + 11'(QUARTER));
        quad_d     = quadrant_of(rel);
        oor_d      = (ang_q < 10'(ANGLE_MIN)) ||
                     (ang_q > 10'(ANGLE_MIN + ANGLE_SPAN - 1));
        state_d    = WAIT;
      end
      WAIT: begin
        state_d = CALC;
      end
      CALC: begin
        // Capture both ROM words from the same address cycle.
        cos_d   = cos_data;
        sin_d   = sin_data;
        state_d = DONE;
      end
      DONE: begin
        out_valid_d = 1'b1;
        out_id_d    = id_q;
        if (oor_q) begin
          out_x_d = wrap_offset(cx_q, rad_q, 1'b0);
          out_y_d = cy_q;
        end else begin
          out_x_d = wrap_offset(cx_q, px, (quad_q == 2'd1) || (quad_q == 2'd2));
          out_y_d = wrap_offset(cy_q, py, quad_q[1]);
        end
        rr_ptr_d = (id_q == 3'(NUM_REQ - 1)) ? '0 : SEL_W'(id_q + 3'd1);
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and visible outputs: cleared by reset, aborting any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      out_x_q     <= '0;
      out_y_q     <= '0;
      cos_addr_q  <= '0;
      sin_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_x_q     <= out_x_d;
      out_y_q     <= out_y_d;
      cos_addr_q  <= cos_addr_d;
      sin_addr_q  <= sin_addr_d;
    end
  end

  // Latched operands and intermediate data; only consumed under FSM control.
  always_ff @(posedge clk) begin
    cx_q   <= cx_d;
    cy_q   <= cy_d;
    rad_q  <= rad_d;
    ang_q  <= ang_d;
    id_q   <= id_d;
    quad_q <= quad_d;
    oor_q  <= oor_d;
    cos_q  <= cos_d;
    sin_q  <= sin_d;
  end

  assign grant     = grant_q;
  assign cos_addr  = cos_addr_q;
  assign sin_addr  = sin_addr_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign out_x     = out_x_q;
  assign out_y     = out_y_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rotation_scheduler.sv
// Bench for rotation_scheduler: directed circle points plus random traffic
// compared cycle by cycle against a behavioural transaction model.
`timescale 1ns/1ps
module tb_rotation_scheduler;

  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0][9:0] center_x, center_y, radius, angle;
  logic [N-1:0]      grant;
  logic [8:0]        cos_addr, sin_addr;
  logic [9:0]        cos_data, sin_data;
  logic              out_valid;
  logic [2:0]        out_id;
  logic [9:0]        out_x, out_y;
  logic              busy;

  int checks = 0;
  int errors = 0;
  int rom[0:447];
  bit mon_en = 1'b0;

  rotation_scheduler #(.NUM_REQ(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .center_x (center_x),
    .center_y (center_y),
    .radius   (radius),
    .angle    (angle),
    .grant    (grant),
    .cos_addr (cos_addr),
    .sin_addr (sin_addr),
    .cos_data (cos_data),
    .sin_data (sin_data),
    .out_valid(out_valid),
    .out_id   (out_id),
    .out_x    (out_x),
    .out_y    (out_y),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  // Both ROMs hold |cos|; the sin port reads it a quarter turn ahead.
  always @(posedge clk) begin
    cos_data <= 10'(rom[cos_addr]);
    sin_data <= 10'(rom[sin_addr]);
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Expected circle point from the geometric rules.
  function automatic void ref_point(input int cx, input int cy, input int r,
                                    input int ang, output int x, output int y);
    int rel, c, s, px, py;
    if (ang < 32 || ang > 479) begin
      x = (cx + r) % 1024;
      y = cy;
    end else begin
      rel = ang - 32;
      c   = rom[rel];
      s   = rom[(rel + 112) % 448];
      px  = r * c / 1000;
      py  = r * s / 1000;
      case (rel / 112)
        0:       begin x = cx + px; y = cy + py; end
        1:       begin x = cx - px; y = cy + py; end
        2:       begin x = cx - px; y = cy - py; end
        default: begin x = cx + px; y = cy - py; end
      endcase
      x = x & 1023;
      y = y & 1023;
    end
  endfunction

  // Transaction-level model: accept when free, result 4 cycles later.
  int           m_cnt = 0, m_ptr = 0;
  logic [N-1:0] m_grant = '0;
  logic         m_valid = 1'b0;
  int           m_id = 0, m_x = 0, m_y = 0;
  int           p_id = 0, p_x = 0, p_y = 0;

  always @(posedge clk) begin
    m_grant = '0;
    m_valid = 1'b0;
    if (rst) begin
      m_cnt = 0; m_ptr = 0; m_id = 0; m_x = 0; m_y = 0;
    end else if (m_cnt == 0) begin
      for (int k = 0; k < N; k++) begin
        logic [1:0] jj;
        jj = 2'((m_ptr + k) % N);
        if (m_grant == '0 && req[jj]) begin
          m_grant[jj] = 1'b1;
          p_id = int'(jj);
          ref_point(int'(center_x[jj]), int'(center_y[jj]), int'(radius[jj]),
                    int'(angle[jj]), p_x, p_y);
          m_cnt = 4;
        end
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_valid = 1'b1;
        m_id = p_id; m_x = p_x; m_y = p_y;
        m_ptr = (p_id + 1) % N;
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check_eq("mon_grant", int'(grant), int'(m_grant));
      check_eq("mon_valid", int'(out_valid), int'(m_valid));
      check_eq("mon_busy", int'(busy), (m_cnt != 0) ? 1 : 0);
      check_eq("mon_out_id", int'(out_id), m_id);
      check_eq("mon_out_x", int'(out_x), m_x);
      check_eq("mon_out_y", int'(out_y), m_y);
    end
  end

  task automatic set_op(input int i, input int cx, input int cy, input int r, input int ang);
    center_x[2'(i)] = 10'(cx);
    center_y[2'(i)] = 10'(cy);
    radius[2'(i)]   = 10'(r);
    angle[2'(i)]    = 10'(ang);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // One requester-0 transaction with literal expected point and latency.
  task automatic single(input string tag, input int cx, input int cy, input int r,
                        input int ang, input int ex, input int ey);
    int lat;
    bit got;
    @(posedge clk); #1;
    set_op(0, cx, cy, r, ang);
    req = 4'b0001;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (grant[0]) got = 1'b1;
    end
    check_eq({tag, "_granted"}, int'(got), 1);
    req = '0;
    lat = 0;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      lat++;
      if (out_valid) got = 1'b1;
    end
    check_eq({tag, "_latency"}, lat, 4);
    check_eq({tag, "_x"}, int'(out_x), ex);
    check_eq({tag, "_y"}, int'(out_y), ey);
    check_eq({tag, "_id"}, int'(out_id), 0);
  endtask

  initial begin
    int   exp_seq[4];
    int   n, nv, last;
    bit   got, saw;
    for (int i = 0; i < 448; i++) begin
      real v;
      v = 1000.0 * $cos(2.0 * 3.14159265358979 * i / 448.0);
      if (v < 0.0) v = -v;
      rom[i] = int'($floor(v + 0.5));
    end
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < N; i++) set_op(i, 320, 240, 100, 32);
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_grant", int'(grant), 0);
    check_eq("rst_valid", int'(out_valid), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_out_x", int'(out_x), 0);
    check_eq("rst_cos_addr", int'(cos_addr), 0);
    check_eq("rst_sin_addr", int'(sin_addr), 0);

    // Four quadrant points on the r=100 circle.
    single("q0", 320, 240, 100, 32, 420, 240);
    single("q1", 320, 240, 100, 144, 320, 340);
    single("q2", 320, 240, 100, 256, 220, 240);
    single("q3", 320, 240, 100, 368, 320, 140);

    // Out-of-range angles.
    single("oor_lo", 320, 240, 100, 20, 420, 240);
    single("oor_hi", 320, 240, 100, 500, 420, 240);

    // Wraparound of coordinate arithmetic.
    single("wrap_x", 5, 240, 100, 256, 929, 240);
    single("wrap_y", 320, 10, 100, 368, 320, 934);

    // Reset while the transaction is in its CALC step.
    @(posedge clk); #1;
    set_op(0, 320, 240, 100, 32);
    req = 4'b0001;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (grant[0]) got = 1'b1;
    end
    check_eq("abort_granted", int'(got), 1);
    req = '0;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", int'(busy), 0);
    check_eq("abort_out_x", int'(out_x), 0);
    check_eq("abort_out_y", int'(out_y), 0);
    check_eq("abort_cos_addr", int'(cos_addr), 0);
    saw = 1'b0;
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check_eq("abort_no_valid", int'(saw), 0);
    @(posedge clk); #1;
    req = 4'b1111;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (grant != '0) begin
        got = 1'b1;
        check_eq("abort_regrant", int'(grant), 1);
      end
    end
    check_eq("abort_regrant_seen", int'(got), 1);
    req = '0;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
    end
    check_eq("abort_regrant_done", int'(got), 1);

    // Round-robin between requesters 0 and 2 held high together.
    do_reset();
    set_op(0, 320, 240, 100, 200);
    set_op(2, 100, 600, 250, 400);
    req = 4'b0101;
    exp_seq = '{0, 2, 0, 2};
    n = 0; nv = 0; last = -1;
    for (int t = 0; t < 80 && nv < 4; t++) begin
      @(negedge clk);
      if (out_valid) begin
        check_eq($sformatf("rr_out_id%0d", nv), int'(out_id), exp_seq[nv]);
        nv++;
      end
      if (grant != '0 && n < 4) begin
        check_eq($sformatf("rr_grant%0d", n), int'(grant), 1 << exp_seq[n]);
        n++;
        if (n == 4) req = '0;
      end
    end
    check_eq("rr_grants", n, 4);
    check_eq("rr_results", nv, 4);

    // Random multi-requester traffic against the model.
    for (int c = 0; c < 500; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        int a;
        a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 1023))
                                        : int'($urandom_range(32, 479));
        if (req[2'(i)] && m_grant[2'(i)]) begin
          if ($urandom_range(0, 1) == 0) req[2'(i)] = 1'b0;
          else set_op(i, $urandom_range(0, 1023), $urandom_range(0, 1023),
                      $urandom_range(0, 1023), a);
        end else if (!req[2'(i)] && $urandom_range(0, 3) == 0) begin
          set_op(i, $urandom_range(0, 1023), $urandom_range(0, 1023),
                 $urandom_range(0, 1023), a);
          req[2'(i)] = 1'b1;
        end
      end
    end
    req = '0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
